div_sched: RTL and testbench
============================

Name: div_sched

Overview:
- Sequencer for the programmable frequency divider.
- Holds a small table of (divisor, pulse-count) slots and plays it out in order. For each slot it drives the divider's config/enable pins, counts divided-clock ticks, then moves to the next slot.
- Sits between the control register block and the divider; optional looping gives repeating multi-rate clock patterns.

Parameters:
- N_SLOTS, 4, number of table entries (power of 2, ≥2)
- DW, 32, divisor width (matches divider DIN_n)
- CW, 16, per-slot pulse-count width

Ports:
- CLK  in  1  system clock; all logic on posedge
- RESET  in  1  synchronous, active-high reset
- WR_EN  in  1  table write strobe
- WR_ADDR  in  log2(N_SLOTS)  slot index to write
- WR_DIV  in  DW  divisor for slot
- WR_CNT  in  CW  divided-clock pulses to emit in slot; 0 = end-of-table marker
- START  in  1  begin sequence at slot 0 (level sampled per cycle)
- STOP  in  1  abort sequence
- LOOP  in  1  restart at slot 0 after last slot instead of finishing
- TICK  in  1  registered one-cycle pulse from divider, one per divided-clock period
- DIV_DIN  out  DW  divisor to divider
- DIV_CONFIG  out  1  divider config strobe
- DIV_ENABLE  out  1  divider enable
- BUSY  out  1  high in LOAD/RUN
- SLOT  out  log2(N_SLOTS)  active slot index
- DONE  out  1  one-cycle pulse on normal completion

Behaviour:
- All outputs registered.
- Reset values:
  - Outputs: DIV_DIN=1, DIV_CONFIG=0, DIV_ENABLE=0, BUSY=0, SLOT=0, DONE=0.
  - State: state=IDLE, tick counter=0.
  - Table: every slot div=1, cnt=0.
- RESET mid-sequence gives the same result next cycle; no DONE pulse.
- States: IDLE, LOAD, RUN.
- IDLE:
  - DIV_ENABLE=0, DIV_CONFIG=0.
  - START with table[0].cnt≠0 → LOAD with SLOT=0.
  - START with table[0].cnt=0 → DONE=1 next cycle, remain IDLE.
- LOAD (exactly one cycle):
  - DIV_CONFIG=1, DIV_ENABLE=0, DIV_DIN=table[SLOT].div; tick counter cleared.
  - Divisor 0 is driven as 1.
  - → RUN.
- RUN:
  - DIV_CONFIG=0, DIV_ENABLE=1; each TICK increments the tick counter.
  - On the TICK that makes counter==table[SLOT].cnt, the next cycle selects the next slot s=SLOT+1:
    - s<N_SLOTS and table[s].cnt≠0 → LOAD slot s.
    - Otherwise, if LOOP=1 (sampled that cycle) → LOAD slot 0.
    - Otherwise → IDLE with DONE=1 for one cycle and SLOT held at last slot.
- Timing:
  - START at cycle t → DIV_CONFIG=1 at t+1 → DIV_ENABLE=1 from t+2.
  - Slot-to-slot gap: exactly one cycle with DIV_ENABLE=0.
- TICK outside RUN is ignored.
- STOP:
  - From any state → IDLE next cycle, DIV_ENABLE=0, no DONE, SLOT unchanged.
  - STOP and START in the same cycle: STOP wins.
- START while BUSY is ignored.
- Table writes:
  - Accepted only in IDLE; ignored while BUSY.
  - A write in the same cycle as START is taken, and START in that cycle uses the pre-write table.
- Counter width is CW; cnt=2^CW−1 must work with no wrap.

Decomposition:
- Package div_sched_pkg holds:
  - state enum (IDLE/LOAD/RUN)
  - slot record typedef {div[DW], cnt[CW]}
  - default constants DIV_RESET=1, CNT_END=0
- One sub-module, div_sched_table: N_SLOTS register file.
  - Sync write with IDLE-gated enable.
  - Async read at SLOT and at SLOT+1 for the next-slot lookahead.
- Top-level div_sched holds the FSM and tick counter.

Test Plan:
- Basic sequence: reset; write slot0={5,3}, slot1={2,2}, slot2.cnt=0; START; TICK each cycle in RUN.
  - DIV_DIN=5 with CONFIG at t+1, RUN for 3 ticks.
  - One-cycle ENABLE=0 gap, then CONFIG with DIN=2, 2 ticks.
  - DONE pulse; BUSY=0; SLOT=1.
- Loop: same table with LOOP=1; run 12 ticks → SLOT sequence 0,1,0,1…, no DONE. Deassert LOOP → DONE after the current slot1 ends.
- Abort: STOP asserted during slot0 after 1 tick → next cycle IDLE, ENABLE=0, DONE=0. A later START restarts at slot0 with the counter cleared (needs 3 fresh ticks).
- Edge cases: table[0].cnt=0 + START → DONE at t+1, no CONFIG. Slot div=0 → DIV_DIN=1 in LOAD. Full table of 4 nonzero slots, LOOP=0 → DONE after slot3.
- Collisions: WR_EN during RUN leaves table unchanged (verify on next run). START+STOP same cycle from IDLE → stays IDLE. RESET during RUN → all outputs at reset values next cycle, table cleared.

Source files
------------

// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider sequencer.
package div_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam int unsigned SLOT_DW = 32;
    localparam int unsigned SLOT_CW = 16;

    typedef struct packed {
        logic [SLOT_DW-1:0] div;
        logic [SLOT_CW-1:0] cnt;
    } slot_t;

    localparam int unsigned DIV_RESET = 1;
    localparam int unsigned CNT_END   = 0;

endpackage

// File: rtl/div_sched_table.sv
// Slot register file: synchronous write, combinational reads of the
// current slot, its successor and slot 0.
module div_sched_table
    import div_sched_pkg::*;
#(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned CW      = 16,
    parameter int unsigned AW      = $clog2(N_SLOTS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_div,
    input  logic [CW-1:0] wr_cnt,
    input  logic [AW-1:0] cur_addr,
    output logic [CW-1:0] cur_cnt,
    output logic [AW-1:0] nxt_addr,
    output logic [DW-1:0] nxt_div,
    output logic          nxt_ok,
    output logic [DW-1:0] head_div,
    output logic [CW-1:0] head_cnt
);

    logic [DW-1:0] div_q [N_SLOTS];
    logic [CW-1:0] cnt_q [N_SLOTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                div_q[i] <= DW'(DIV_RESET);
                cnt_q[i] <= CW'(CNT_END);
            end
        end else if (wr_en) begin
            div_q[wr_addr] <= wr_div;
            cnt_q[wr_addr] <= wr_cnt;
        end
    end

    // Successor index wraps in AW bits, so the last slot is excluded explicitly.
    assign nxt_addr = cur_addr + AW'(1);
    assign cur_cnt  = cnt_q[cur_addr];
    assign nxt_div  = div_q[nxt_addr];
    assign nxt_ok   = (cur_addr != AW'(N_SLOTS - 1)) && (cnt_q[nxt_addr] != CW'(CNT_END));
    assign head_div = div_q[0];
    assign head_cnt = cnt_q[0];

endmodule

// File: rtl/div_sched.sv
// Divider sequencer: plays the slot table out as LOAD/RUN pairs, counting
// divided-clock ticks per slot, with optional looping back to slot 0.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int unsigned N_SLOTS = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned CW      = 16,
    localparam int unsigned AW     = $clog2(N_SLOTS)
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          WR_EN,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [DW-1:0] WR_DIV,
    input  logic [CW-1:0] WR_CNT,
    input  logic          START,
    input  logic          STOP,
    input  logic          LOOP,
    input  logic          TICK,
    output logic [DW-1:0] DIV_DIN,
    output logic          DIV_CONFIG,
    output logic          DIV_ENABLE,
    output logic          BUSY,
    output logic [AW-1:0] SLOT,
    output logic          DONE
);

    state_t        state_q, state_d;
    logic [AW-1:0] slot_q, slot_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [DW-1:0] din_q, din_d;
    logic          cfg_q, cfg_d;
    logic          en_q, en_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] cur_cnt;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_div;
    logic          nxt_ok;
    logic [DW-1:0] head_div;
    logic [CW-1:0] head_cnt;

    div_sched_table #(
        .N_SLOTS (N_SLOTS),
        .DW      (DW),
        .CW      (CW),
        .AW      (AW)
    ) u_table (
        .clk      (CLK),
        .reset    (RESET),
        .wr_en    (WR_EN && (state_q == IDLE)),
        .wr_addr  (WR_ADDR),
        .wr_div   (WR_DIV),
        .wr_cnt   (WR_CNT),
        .cur_addr (slot_q),
        .cur_cnt  (cur_cnt),
        .nxt_addr (nxt_addr),
        .nxt_div  (nxt_div),
        .nxt_ok   (nxt_ok),
        .head_div (head_div),
        .head_cnt (head_cnt)
    );

    function automatic logic [DW-1:0] nz_div(input logic [DW-1:0] d);
        return (d == '0) ? DW'(DIV_RESET) : d;
    endfunction

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        tick_d  = tick_q;
        din_d   = din_q;
        cfg_d   = 1'b0;
        en_d    = 1'b0;
        done_d  = 1'b0;
        if (STOP) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        if (head_cnt != CW'(CNT_END)) begin
                            state_d = LOAD;
                            slot_d  = '0;
                            din_d   = nz_div(head_div);
                            cfg_d   = 1'b1;
                            tick_d  = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    state_d = RUN;
                    en_d    = 1'b1;
                end
                RUN: begin
                    en_d = 1'b1;
                    if (TICK) begin
                        tick_d = tick_q + CW'(1);
                        if (tick_d == cur_cnt) begin
                            en_d   = 1'b0;
                            tick_d = '0;
                            if (nxt_ok) begin
                                state_d = LOAD;
                                slot_d  = nxt_addr;
                                din_d   = nz_div(nxt_div);
                                cfg_d   = 1'b1;
                            end else if (LOOP) begin
                                state_d = LOAD;
                                slot_d  = '0;
                                din_d   = nz_div(head_div);
                                cfg_d   = 1'b1;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            slot_q  <= '0;
            tick_q  <= '0;
            din_q   <= DW'(DIV_RESET);
            cfg_q   <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            tick_q  <= tick_d;
            din_q   <= din_d;
            cfg_q   <= cfg_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign DIV_DIN    = din_q;
    assign DIV_CONFIG = cfg_q;
    assign DIV_ENABLE = en_q;
    assign BUSY       = busy_q;
    assign SLOT       = slot_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: config/done events are checked by a monitor
// against a queue of expected events; timing points are checked inline.
module tb_div_sched;

    logic        CLK;
    logic        RESET;
    logic        WR_EN;
    logic [1:0]  WR_ADDR;
    logic [31:0] WR_DIV;
    logic [15:0] WR_CNT;
    logic        START;
    logic        STOP;
    logic        LOOP;
    logic        TICK;
    logic [31:0] DIV_DIN;
    logic        DIV_CONFIG;
    logic        DIV_ENABLE;
    logic        BUSY;
    logic [1:0]  SLOT;
    logic        DONE;

    div_sched #(.N_SLOTS(4), .DW(32), .CW(16)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .WR_EN      (WR_EN),
        .WR_ADDR    (WR_ADDR),
        .WR_DIV     (WR_DIV),
        .WR_CNT     (WR_CNT),
        .START      (START),
        .STOP       (STOP),
        .LOOP       (LOOP),
        .TICK       (TICK),
        .DIV_DIN    (DIV_DIN),
        .DIV_CONFIG (DIV_CONFIG),
        .DIV_ENABLE (DIV_ENABLE),
        .BUSY       (BUSY),
        .SLOT       (SLOT),
        .DONE       (DONE)
    );

    typedef struct {
        bit          done;
        logic [1:0]  slot;
        logic [31:0] din;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  total = 0;
    int  bad   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input int d, input int c);
        WR_EN = 1'b1; WR_ADDR = 2'(a); WR_DIV = 32'(d); WR_CNT = 16'(c);
        step();
        WR_EN = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            step();
            if (DONE) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: got no DONE want DONE within %0d cycles", max_cycles);
        end
    endtask

    task automatic exp_cfg(input int s, input int d);
        ev_t e;
        e.done = 1'b0; e.slot = 2'(s); e.din = 32'(d);
        exp_q.push_back(e);
    endtask

    task automatic exp_done(input int s);
        ev_t e;
        e.done = 1'b1; e.slot = 2'(s); e.din = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_full(input int d0);
        exp_cfg(0, d0); exp_cfg(1, 4); exp_cfg(2, 6); exp_cfg(3, 9); exp_done(3);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_din"}, DIV_DIN, 1);
        chk({tag, "_cfg"}, 32'(DIV_CONFIG), 0);
        chk({tag, "_en"}, 32'(DIV_ENABLE), 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_slot"}, 32'(SLOT), 0);
        chk({tag, "_done"}, 32'(DONE), 0);
    endtask

    // Monitor: every config strobe or done pulse must match the next expected event.
    always @(negedge CLK) begin
        if (!RESET && (DIV_CONFIG || DONE)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got config=%0b done=%0b slot=%0d want no event",
                         DIV_CONFIG, DONE, SLOT);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_kind", 32'(DONE), 32'(mon_e.done));
                chk("ev_slot", 32'(SLOT), 32'(mon_e.slot));
                if (!mon_e.done) chk("ev_din", DIV_DIN, mon_e.din);
            end
        end
    end

    initial begin
        RESET = 1'b1; WR_EN = 1'b0; WR_ADDR = '0; WR_DIV = '0; WR_CNT = '0;
        START = 1'b0; STOP = 1'b0; LOOP = 1'b0; TICK = 1'b0;
        step(); step();
        chk_reset_vals("rst");
        RESET = 1'b0;

        // Basic two-slot sequence, TICK every cycle
        wr(0, 5, 3); wr(1, 2, 2);
        TICK = 1'b1;
        exp_cfg(0, 5); exp_cfg(1, 2); exp_done(1);
        START = 1'b1; step(); START = 1'b0;
        chk("b_cfg", 32'(DIV_CONFIG), 1);
        chk("b_en_load", 32'(DIV_ENABLE), 0);
        chk("b_busy", 32'(BUSY), 1);
        step();
        chk("b_en_run", 32'(DIV_ENABLE), 1);
        repeat (3) step();
        chk("b_gap_en", 32'(DIV_ENABLE), 0);
        chk("b_din1", DIV_DIN, 2);
        chk("b_slot1", 32'(SLOT), 1);
        repeat (3) step();
        chk("b_done", 32'(DONE), 1);
        chk("b_idle", 32'(BUSY), 0);
        chk("b_slot_end", 32'(SLOT), 1);

        // Looping: three passes, LOOP dropped during the third slot 1
        for (int i = 0; i < 3; i++) begin
            exp_cfg(0, 5); exp_cfg(1, 2);
        end
        exp_done(1);
        LOOP = 1'b1; START = 1'b1; step(); START = 1'b0;
        repeat (18) step();
        chk("l_slot", 32'(SLOT), 1);
        chk("l_cfg", 32'(DIV_CONFIG), 1);
        LOOP = 1'b0;
        repeat (3) step();
        chk("l_done", 32'(DONE), 1);

        // Abort after one tick, then restart with a fresh counter
        exp_cfg(0, 5);
        START = 1'b1; step(); START = 1'b0;
        step(); step();
        STOP = 1'b1; step(); STOP = 1'b0;
        chk("a_en", 32'(DIV_ENABLE), 0);
        chk("a_busy", 32'(BUSY), 0);
        chk("a_done", 32'(DONE), 0);
        chk("a_slot", 32'(SLOT), 0);
        step();
        chk("a_done_late", 32'(DONE), 0);
        exp_cfg(0, 5); exp_cfg(1, 2); exp_done(1);
        START = 1'b1; step(); START = 1'b0;
        repeat (4) step();
        chk("a_restart_slot", 32'(SLOT), 1);
        chk("a_restart_cfg", 32'(DIV_CONFIG), 1);
        wait_done(10);

        // START and STOP together: STOP wins
        START = 1'b1; STOP = 1'b1; step(); START = 1'b0; STOP = 1'b0;
        chk("ss_busy", 32'(BUSY), 0);
        chk("ss_cfg", 32'(DIV_CONFIG), 0);
        step();

        // Empty table: immediate DONE, no config
        RESET = 1'b1; step(); RESET = 1'b0;
        wr(0, 7, 0);
        exp_done(0);
        START = 1'b1; step(); START = 1'b0;
        chk("e_done", 32'(DONE), 1);
        chk("e_cfg", 32'(DIV_CONFIG), 0);
        chk("e_busy", 32'(BUSY), 0);
        step();
        chk("e_done_pulse", 32'(DONE), 0);

        // Divisor 0 is presented as 1
        wr(0, 0, 1);
        exp_cfg(0, 1); exp_done(0);
        START = 1'b1; step(); START = 1'b0;
        chk("z_din", DIV_DIN, 1);
        wait_done(10);

        // Full table, write during RUN must be dropped
        wr(0, 3, 1); wr(1, 4, 2); wr(2, 6, 1); wr(3, 9, 1);
        exp_full(3);
        START = 1'b1; step(); START = 1'b0;
        step();
        wr(0, 11, 5);
        wait_done(30);
        chk("f_slot", 32'(SLOT), 3);

        // Write alongside START: this run uses old slot 0, next run the new one
        exp_full(3);
        WR_EN = 1'b1; WR_ADDR = 2'd0; WR_DIV = 32'd13; WR_CNT = 16'd2;
        START = 1'b1; step(); START = 1'b0; WR_EN = 1'b0;
        wait_done(30);

        // Reset mid-run clears outputs and table
        exp_cfg(0, 13);
        START = 1'b1; step(); START = 1'b0;
        step(); step();
        RESET = 1'b1; step();
        chk_reset_vals("rr");
        RESET = 1'b0;
        exp_done(0);
        START = 1'b1; step(); START = 1'b0;
        chk("rr_empty_done", 32'(DONE), 1);
        step(); step();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
